// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_fifo_ctrl
// Brief   : CPU-mapped UART with TX/RX FIFOs, parity, sticky errors, interrupt.
// Revision: 1.0
// ============================================================================
module uart_fifo_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic [1:0] i_addr,
    input  logic       i_ncs,
    input  logic       i_no,
    input  logic       i_nw,
    inout  wire  [7:0] io_data,
    output logic       o_nint,
    input  logic       i_rx,
    output logic       o_tx
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = 9 + $clog2(PRESCALE + 1);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic             r_en, r_par_en, r_par_odd, r_ovr, r_ferr, r_perr, r_nint;
    logic [7:0]       r_mask, r_baud;
    logic             r_wr_d, r_rd_d, r_rx_s1, r_rx_s2, r_rx_s3;
    logic [WIDTH-1:0] r_txm [DEPTH];
    logic [WIDTH-1:0] r_rxm [DEPTH];
    logic [AW:0]      r_txw, r_txr, r_rxw, r_rxr;
    state_t           r_tx_st, r_rx_st, w_tx_st_n, w_rx_st_n;
    logic [CW-1:0]    r_tx_cnt, r_rx_cnt, w_tx_cnt_n, w_rx_cnt_n;
    logic [BW-1:0]    r_tx_idx, r_rx_idx, w_tx_idx_n, w_rx_idx_n;
    logic [WIDTH-1:0] r_tx_sh, r_rx_sh, w_tx_sh_n, w_rx_sh_n;
    logic             r_tx_par, w_tx_par_n, r_rx_pbad, w_rx_pbad_n;
    logic             w_tx_pop, w_tx_load, w_rx_push_req, w_ferr_set, w_perr_set;

    logic [CW-1:0] w_bit_m1, w_half;
    assign w_bit_m1 = (CW'(r_baud) + CW'(1)) * CW'(PRESCALE) - CW'(1);
    assign w_half   = w_bit_m1 >> 1;

    // Bus strobes: writes act on the first strobe cycle, DATA pops at strobe end.
    logic w_wr, w_wr_p, w_rd_bus, w_rd_data, w_pop_req, w_clr, w_flush, w_en_nx;
    assign w_wr      = !i_ncs && !i_nw;
    assign w_wr_p    = w_wr && !r_wr_d;
    assign w_rd_bus  = !i_ncs && !i_no && i_nw;
    assign w_rd_data = w_rd_bus && (i_addr == 2'd2);
    assign w_pop_req = r_rd_d && !w_rd_data;
    assign w_clr     = w_wr_p && (i_addr == 2'd0) && io_data[4];
    assign w_flush   = w_wr_p && (i_addr == 2'd0) && io_data[5];
    assign w_en_nx   = (w_wr_p && (i_addr == 2'd0)) ? io_data[0] : r_en;

    logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_push, w_rx_pop, w_rx_push, w_ovr_set;
    assign w_tx_empty = (r_txw == r_txr);
    assign w_tx_full  = (r_txw[AW] != r_txr[AW]) && (r_txw[AW-1:0] == r_txr[AW-1:0]);
    assign w_rx_empty = (r_rxw == r_rxr);
    assign w_rx_full  = (r_rxw[AW] != r_rxr[AW]) && (r_rxw[AW-1:0] == r_rxr[AW-1:0]);
    assign w_tx_push  = w_wr_p && (i_addr == 2'd2) && r_en && !w_tx_full;
    assign w_rx_pop   = w_pop_req && !w_rx_empty;
    assign w_rx_push  = w_rx_push_req && (!w_rx_full || w_rx_pop);
    assign w_ovr_set  = w_rx_push_req && w_rx_full && !w_rx_pop;

    logic [7:0] w_status, w_rdata;
    assign w_status = {r_perr, r_ferr, r_ovr, !w_rx_empty, (r_tx_st != S_IDLE),
                       w_tx_empty, w_tx_full, r_en};

    always_comb begin
        w_rdata = w_status;
        case (i_addr)
            2'd1:    w_rdata = r_mask;
            2'd2:    w_rdata = w_rx_empty ? 8'h00 : 8'(r_rxm[r_rxr[AW-1:0]]);
            2'd3:    w_rdata = r_baud;
            default: w_rdata = w_status;
        endcase
    end
    assign io_data = w_rd_bus ? w_rdata : 8'bz;
    assign o_nint  = r_nint;

    always_comb begin
        w_tx_st_n = r_tx_st; w_tx_cnt_n = r_tx_cnt; w_tx_idx_n = r_tx_idx;
        w_tx_sh_n = r_tx_sh; w_tx_par_n = r_tx_par; w_tx_pop = 1'b0; w_tx_load = 1'b0;
        if (!w_en_nx) begin
            w_tx_st_n  = S_IDLE;
            w_tx_cnt_n = '0;
        end else if (r_tx_st == S_IDLE) begin
            w_tx_load = !w_tx_empty;
        end else if (r_tx_cnt != '0) begin
            w_tx_cnt_n = r_tx_cnt - CW'(1);
        end else begin
            w_tx_cnt_n = w_bit_m1;
            case (r_tx_st)
                S_START: begin w_tx_st_n = S_DATA; w_tx_idx_n = '0; end
                S_DATA: begin
                    w_tx_sh_n  = r_tx_sh >> 1;
                    w_tx_idx_n = r_tx_idx + BW'(1);
                    if (r_tx_idx == BW'(WIDTH - 1)) w_tx_st_n = r_par_en ? S_PAR : S_STOP;
                end
                S_PAR:   w_tx_st_n = S_STOP;
                default: begin w_tx_st_n = S_IDLE; w_tx_load = !w_tx_empty; end
            endcase
        end
        // Next word is fetched straight out of STOP so frames run back to back.
        if (w_tx_load) begin
            w_tx_pop   = 1'b1;
            w_tx_st_n  = S_START;
            w_tx_cnt_n = w_bit_m1;
            w_tx_sh_n  = r_txm[r_txr[AW-1:0]];
            w_tx_par_n = (^r_txm[r_txr[AW-1:0]]) ^ r_par_odd;
        end
    end

    always_comb begin
        case (r_tx_st)
            S_START: o_tx = 1'b0;
            S_DATA:  o_tx = r_tx_sh[0];
            S_PAR:   o_tx = r_tx_par;
            default: o_tx = 1'b1;
        endcase
    end

    always_comb begin
        w_rx_st_n = r_rx_st; w_rx_cnt_n = r_rx_cnt; w_rx_idx_n = r_rx_idx;
        w_rx_sh_n = r_rx_sh; w_rx_pbad_n = r_rx_pbad;
        w_rx_push_req = 1'b0; w_ferr_set = 1'b0; w_perr_set = 1'b0;
        if (!w_en_nx) begin
            w_rx_st_n  = S_IDLE;
            w_rx_cnt_n = '0;
        end else if (r_rx_st == S_IDLE) begin
            if (!r_rx_s2 && r_rx_s3) begin
                w_rx_st_n  = S_START;
                w_rx_cnt_n = w_half;
            end
        end else if (r_rx_cnt != '0) begin
            w_rx_cnt_n = r_rx_cnt - CW'(1);
        end else begin
            w_rx_cnt_n = w_bit_m1;
            case (r_rx_st)
                S_START: begin
                    w_rx_st_n   = r_rx_s2 ? S_IDLE : S_DATA;
                    w_rx_idx_n  = '0;
                    w_rx_pbad_n = 1'b0;
                end
                S_DATA: begin
                    w_rx_sh_n  = {r_rx_s2, r_rx_sh[WIDTH-1:1]};
                    w_rx_idx_n = r_rx_idx + BW'(1);
                    if (r_rx_idx == BW'(WIDTH - 1)) w_rx_st_n = r_par_en ? S_PAR : S_STOP;
                end
                S_PAR: begin
                    w_rx_pbad_n = r_rx_s2 != ((^r_rx_sh) ^ r_par_odd);
                    w_rx_st_n   = S_STOP;
                end
                default: begin
                    w_rx_push_req = 1'b1;
                    w_ferr_set    = !r_rx_s2;
                    w_perr_set    = r_rx_pbad;
                    w_rx_st_n     = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_en <= 1'b0; r_par_en <= 1'b0; r_par_odd <= 1'b0;
            r_mask <= '0; r_baud <= '0; r_nint <= 1'b1;
            r_ovr <= 1'b0; r_ferr <= 1'b0; r_perr <= 1'b0;
            r_wr_d <= 1'b0; r_rd_d <= 1'b0;
            r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_s3 <= 1'b1;
            r_txw <= '0; r_txr <= '0; r_rxw <= '0; r_rxr <= '0;
            r_tx_st <= S_IDLE; r_tx_cnt <= '0; r_tx_idx <= '0; r_tx_sh <= '0; r_tx_par <= 1'b0;
            r_rx_st <= S_IDLE; r_rx_cnt <= '0; r_rx_idx <= '0; r_rx_sh <= '0; r_rx_pbad <= 1'b0;
        end else begin
            r_wr_d  <= w_wr;
            r_rd_d  <= w_rd_data;
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
            if (w_wr_p && i_addr == 2'd0) begin
                r_en <= io_data[0]; r_par_en <= io_data[1]; r_par_odd <= io_data[2];
            end
            if (w_wr_p && i_addr == 2'd1) r_mask <= io_data;
            if (w_wr_p && i_addr == 2'd3 && !r_en) r_baud <= io_data;
            // A new error in the same cycle as CLR_ERR keeps the flag set.
            r_ovr  <= (r_ovr  && !w_clr) || w_ovr_set;
            r_ferr <= (r_ferr && !w_clr) || (w_rx_push_req && w_ferr_set);
            r_perr <= (r_perr && !w_clr) || (w_rx_push_req && w_perr_set);
            r_nint <= ~|(w_status[7:2] & r_mask[7:2]);
            if (w_flush) begin
                r_txr <= r_txw;
                r_rxr <= r_rxw;
            end else begin
                if (w_tx_push) r_txw <= r_txw + 1'b1;
                if (w_tx_pop)  r_txr <= r_txr + 1'b1;
                if (w_rx_push) r_rxw <= r_rxw + 1'b1;
                if (w_rx_pop)  r_rxr <= r_rxr + 1'b1;
            end
            r_tx_st <= w_tx_st_n; r_tx_cnt <= w_tx_cnt_n; r_tx_idx <= w_tx_idx_n;
            r_tx_sh <= w_tx_sh_n; r_tx_par <= w_tx_par_n;
            r_rx_st <= w_rx_st_n; r_rx_cnt <= w_rx_cnt_n; r_rx_idx <= w_rx_idx_n;
            r_rx_sh <= w_rx_sh_n; r_rx_pbad <= w_rx_pbad_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_tx_push && !w_flush) r_txm[r_txw[AW-1:0]] <= io_data[WIDTH-1:0];
        if (w_rx_push && !w_flush) r_rxm[r_rxw[AW-1:0]] <= r_rx_sh;
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_fifo_ctrl
// Brief   : Directed self-checking bench for uart_fifo_ctrl (DEPTH=4, BAUD=3).
// Revision: 1.0
// ============================================================================
module tb_uart_fifo_ctrl;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [1:0] addr = 2'd0;
    logic       ncs = 1'b1, no = 1'b1, nw = 1'b1;
    logic       r_drv = 1'b0;
    logic [7:0] r_wdata = 8'h00;
    logic       r_loop = 1'b0, r_rx_drv = 1'b1;
    wire  [7:0] w_bus;
    wire        w_rx;
    logic       nint, tx;
    int         n_tests = 0, n_fail = 0;
    logic [7:0] mon_q [$];
    logic       mon_en = 1'b0;

    always #5 clk = ~clk;

    assign w_bus = r_drv ? r_wdata : 8'bz;
    assign w_rx  = r_loop ? tx : r_rx_drv;

    uart_fifo_ctrl #(.WIDTH(8), .DEPTH(4), .PRESCALE(1)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_addr(addr), .i_ncs(ncs), .i_no(no), .i_nw(nw),
        .io_data(w_bus), .o_nint(nint), .i_rx(w_rx), .o_tx(tx)
    );

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;   // write data, or expected read value
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; r_wdata = d; r_drv = 1'b1; ncs = 1'b0; nw = 1'b0; no = 1'b1;
        @(negedge clk);
        ncs = 1'b1; nw = 1'b1; r_drv = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; ncs = 1'b0; no = 1'b0; nw = 1'b1;
        @(negedge clk);
        d = w_bus;
        ncs = 1'b1; no = 1'b1;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        chk(nm, d, exp);
    endtask

    // Called right after the write that queues the frame; samples mid-bit.
    task automatic check_frame(input string nm, input logic [10:0] bits, input int n);
        repeat (2) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_bit%0d", nm, i), 8'(tx), 8'(bits[i]));
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic rx_frame(input logic [10:0] bits, input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            r_rx_drv = bits[i];
            repeat (4) @(negedge clk);
        end
        r_rx_drv = 1'b1;
    endtask

    // Line monitor for 8N1 frames at 4 clocks per bit.
    initial forever begin
        @(negedge clk);
        if (mon_en && tx === 1'b0) begin : mon_frame
            logic [7:0] b;
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk);
                b[i] = tx;
            end
            repeat (4) @(negedge clk);
            mon_q.push_back(b);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b0, 2'd0, 8'h04};
        tbl[1]  = '{1'b0, 2'd1, 8'h00};
        tbl[2]  = '{1'b0, 2'd3, 8'h00};
        tbl[3]  = '{1'b0, 2'd2, 8'h00};
        tbl[4]  = '{1'b1, 2'd1, 8'hA5};
        tbl[5]  = '{1'b0, 2'd1, 8'hA5};
        tbl[6]  = '{1'b1, 2'd3, 8'h03};
        tbl[7]  = '{1'b0, 2'd3, 8'h03};
        tbl[8]  = '{1'b1, 2'd1, 8'h00};
        tbl[9]  = '{1'b1, 2'd2, 8'h55};
        tbl[10] = '{1'b0, 2'd0, 8'h04};
        tbl[11] = '{1'b1, 2'd0, 8'h01};
        tbl[12] = '{1'b0, 2'd0, 8'h05};
        tbl[13] = '{1'b1, 2'd3, 8'h07};
        tbl[14] = '{1'b0, 2'd3, 8'h03};
        tbl[15] = '{1'b1, 2'd0, 8'h00};

        repeat (3) @(negedge clk);
        chk("rst_tx", 8'(tx), 8'h01);
        chk("rst_nint", 8'(nint), 8'h01);
        nrst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
            else rd_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].data);
        end

        // T1: 0xA5, 8N1
        bus_write(2'd0, 8'h01);
        bus_write(2'd2, 8'hA5);
        check_frame("t1", {1'b0, 1'b1, 8'hA5, 1'b0}, 10);
        rd_chk("t1_status", 2'd0, 8'h05);

        // T2: odd parity, looped back
        r_loop = 1'b1;
        bus_write(2'd0, 8'h07);
        bus_write(2'd2, 8'h03);
        check_frame("t2", {1'b1, 1'b1, 8'h03, 1'b0}, 11);
        repeat (4) @(negedge clk);
        rd_chk("t2_status", 2'd0, 8'h15);
        rd_chk("t2_data", 2'd2, 8'h03);
        rd_chk("t2_status2", 2'd0, 8'h05);
        r_loop = 1'b0;

        // T3: TX FIFO overflow
        bus_write(2'd0, 8'h01);
        mon_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) bus_write(2'd2, 8'(8'h11 + i));
        rd_chk("t3_full", 2'd0, 8'h0B);
        for (int c = 0; c < 400 && mon_q.size() < 5; c++) @(negedge clk);
        repeat (12) @(negedge clk);
        chk("t3_count", 8'(mon_q.size()), 8'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t3_word%0d", i), (i < mon_q.size()) ? mon_q[i] : 8'hxx, 8'(8'h11 + i));
        mon_en = 1'b0;
        rd_chk("t3_status", 2'd0, 8'h05);

        // T4: RX overrun and interrupt
        bus_write(2'd1, 8'h20);
        r_loop = 1'b1;
        for (int i = 0; i < 5; i++) bus_write(2'd2, 8'(8'h21 + i));
        repeat (260) @(negedge clk);
        chk("t4_nint", 8'(nint), 8'h00);
        rd_chk("t4_status", 2'd0, 8'h35);
        bus_write(2'd0, 8'h11);
        repeat (2) @(negedge clk);
        chk("t4_nint_clr", 8'(nint), 8'h01);
        rd_chk("t4_status2", 2'd0, 8'h15);
        for (int i = 0; i < 4; i++) rd_chk($sformatf("t4_data%0d", i), 2'd2, 8'(8'h21 + i));
        rd_chk("t4_empty_status", 2'd0, 8'h05);
        rd_chk("t4_empty_data", 2'd2, 8'h00);
        rd_chk("t4_status3", 2'd0, 8'h05);
        r_loop = 1'b0;
        bus_write(2'd1, 8'h00);

        // T5: framing error, then glitch rejection
        rx_frame({1'b0, 1'b0, 8'h5A, 1'b0}, 10);
        repeat (8) @(negedge clk);
        rd_chk("t5_status", 2'd0, 8'h55);
        rd_chk("t5_data", 2'd2, 8'h5A);
        rd_chk("t5_status2", 2'd0, 8'h45);
        bus_write(2'd0, 8'h11);
        rd_chk("t5_clr", 2'd0, 8'h05);
        @(negedge clk); r_rx_drv = 1'b0;
        @(negedge clk); r_rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        rd_chk("t5_glitch", 2'd0, 8'h05);

        // T6: asynchronous reset mid-frame, BAUD locked while enabled
        bus_write(2'd2, 8'h00);
        repeat (10) @(negedge clk);
        chk("t6_tx_mid", 8'(tx), 8'h00);
        #2 nrst = 1'b0;
        #1 chk("t6_tx_rst", 8'(tx), 8'h01);
        chk("t6_nint_rst", 8'(nint), 8'h01);
        addr = 2'd0; ncs = 1'b0; no = 1'b0; nw = 1'b1;
        #1 chk("t6_status_rst", w_bus, 8'h04);
        ncs = 1'b1; no = 1'b1;
        @(negedge clk); nrst = 1'b1;
        bus_write(2'd0, 8'h01);
        bus_write(2'd3, 8'h09);
        rd_chk("t6_baud", 2'd3, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
